// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, MIPS field split of the held instruction, and a
// saturating count of flushes that actually killed a beat.
module if_id_stage_reg #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [PC_W-1:0]  pc_plus4_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      id_instr,
  output logic [5:0]       id_opcode,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_shamt,
  output logic [5:0]       id_func,
  output logic [15:0]      id_imm,
  output logic [25:0]      id_addr,
  output logic [PC_W-1:0]  id_pc_plus4,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned INSTR_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Occupancy is implied by the two valid bits; this is just a decoded view.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;

  state_e state_c;
  logic   accept_c;
  logic   pop_c;

  // Handshake: in_ready comes straight from a flop, out_valid is masked by flush.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q & ~flush;
  assign accept_c  = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  // Decode occupancy from the valid bits.
  always_comb begin
    state_c = ST_EMPTY;
    if (main_valid_q) begin
      state_c = skid_valid_q ? ST_TWO : ST_ONE;
    end
  end

  // Next-state: flush wins, otherwise shift beats in order through skid/main.
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    cnt_d        = cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_instr_d = '0;
      main_pc_d    = '0;
      skid_valid_d = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      if ((main_valid_q | skid_valid_q | accept_c) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      case (state_c)
        ST_EMPTY: begin
          if (accept_c) begin
            main_valid_d = 1'b1;
            main_instr_d = instr_in;
            main_pc_d    = pc_plus4_in;
          end
        end
        ST_ONE: begin
          if (accept_c && pop_c) begin
            main_instr_d = instr_in;
            main_pc_d    = pc_plus4_in;
          end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_instr_d = instr_in;
            skid_pc_d    = pc_plus4_in;
          end else if (pop_c) begin
            main_valid_d = 1'b0;
            main_instr_d = '0;
            main_pc_d    = '0;
          end
        end
        ST_TWO: begin
          if (pop_c) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  // Field split of the held instruction.
  assign id_instr    = main_instr_q;
  assign id_opcode   = main_instr_q[31:26];
  assign id_rs       = main_instr_q[25:21];
  assign id_rt       = main_instr_q[20:16];
  assign id_rd       = main_instr_q[15:11];
  assign id_shamt    = main_instr_q[10:6];
  assign id_func     = main_instr_q[5:0];
  assign id_imm      = main_instr_q[15:0];
  assign id_addr     = main_instr_q[25:0];
  assign id_pc_plus4 = main_pc_q;
  assign flush_cnt   = cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: queue-based reference model plus directed and
// random stimulus; a second instance with CNT_W=2 exercises saturation.
module tb_if_id_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_plus4_in;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] id_instr, id_pc_plus4;
  logic [5:0]  id_opcode, id_func;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;
  logic [25:0] id_addr;
  logic [15:0] flush_cnt;

  logic        in_ready2, out_valid2;
  logic [31:0] id_instr2, id_pc_plus42;
  logic [5:0]  id_opcode2, id_func2;
  logic [4:0]  id_rs2, id_rt2, id_rd2, id_shamt2;
  logic [15:0] id_imm2;
  logic [25:0] id_addr2;
  logic [1:0]  flush_cnt2;

  int tests  = 0;
  int errors = 0;

  // Model: FIFO of {instr, pc} beats (depth 2) and total effective flushes.
  logic [63:0] mq[$];
  int          total = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  if_id_stage_reg #(.PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_plus4_in(pc_plus4_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_func(id_func), .id_imm(id_imm),
    .id_addr(id_addr), .id_pc_plus4(id_pc_plus4), .flush_cnt(flush_cnt)
  );

  if_id_stage_reg #(.PC_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instr_in(instr_in), .pc_plus4_in(pc_plus4_in), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .id_instr(id_instr2),
    .id_opcode(id_opcode2), .id_rs(id_rs2), .id_rt(id_rt2), .id_rd(id_rd2),
    .id_shamt(id_shamt2), .id_func(id_func2), .id_imm(id_imm2),
    .id_addr(id_addr2), .id_pc_plus4(id_pc_plus42), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model update: flush kills everything, else pop front / push back.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        total = 0;
      end else if (flush) begin
        if (mq.size() > 0 || (in_valid && mq.size() < 2)) total++;
        mq.delete();
      end else begin
        if (in_valid && mq.size() < 2 && mq.size() > 0 && out_ready) begin
          void'(mq.pop_front());
          mq.push_back({instr_in, pc_plus4_in});
        end else if (mq.size() > 0 && out_ready) begin
          void'(mq.pop_front());
        end else if (in_valid && mq.size() < 2) begin
          mq.push_back({instr_in, pc_plus4_in});
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle on the falling edge.
  initial begin
    logic [31:0] ei, ep;
    logic        ev, er;
    forever begin
      @(negedge clk);
      ei = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      ep = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
      ev = (mq.size() > 0) && !flush;
      er = (mq.size() < 2);
      chk("in_ready",    64'(in_ready),    64'(er));
      chk("out_valid",   64'(out_valid),   64'(ev));
      chk("id_instr",    64'(id_instr),    64'(ei));
      chk("id_opcode",   64'(id_opcode),   64'(ei[31:26]));
      chk("id_rs",       64'(id_rs),       64'(ei[25:21]));
      chk("id_rt",       64'(id_rt),       64'(ei[20:16]));
      chk("id_rd",       64'(id_rd),       64'(ei[15:11]));
      chk("id_shamt",    64'(id_shamt),    64'(ei[10:6]));
      chk("id_func",     64'(id_func),     64'(ei[5:0]));
      chk("id_imm",      64'(id_imm),      64'(ei[15:0]));
      chk("id_addr",     64'(id_addr),     64'(ei[25:0]));
      chk("id_pc_plus4", 64'(id_pc_plus4), 64'(ep));
      chk("flush_cnt",   64'(flush_cnt),   64'((total > 65535) ? 65535 : total));
      chk("flush_cnt2",  64'(flush_cnt2),  64'((total > 3) ? 3 : total));
      chk("out_valid2",  64'(out_valid2),  64'(ev));
      chk("id_instr2",   64'(id_instr2),   64'(ei));
      if (out_valid && out_ready) got.push_back(id_instr);
    end
  end

  initial begin
    logic [31:0] a, b, c, y;
    a = 32'h1111_0001;
    b = 32'h2222_0002;
    c = 32'h3333_0003;
    y = 32'hDEAD_BEEF;
    rst_n = 1'b0; in_valid = 1'b0; instr_in = '0; pc_plus4_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr",     64'(id_instr),  64'd0);
    chk("rst_cnt",       64'(flush_cnt), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Reset then stream one add instruction.
    in_valid = 1'b1; instr_in = 32'h012A_4020; pc_plus4_in = 32'h4; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid),   64'd1);
    chk("t1_opcode",    64'(id_opcode),   64'd0);
    chk("t1_rs",        64'(id_rs),       64'd9);
    chk("t1_rt",        64'(id_rt),       64'd10);
    chk("t1_rd",        64'(id_rd),       64'd8);
    chk("t1_func",      64'(id_func),     64'h20);
    chk("t1_pc",        64'(id_pc_plus4), 64'h4);
    step();

    // Back-pressure: A, B absorbed, C stalled, then drained in order.
    out_ready = 1'b0; in_valid = 1'b1; instr_in = a; pc_plus4_in = 32'h8;
    step();
    instr_in = b; pc_plus4_in = 32'hC;
    step();
    instr_in = c; pc_plus4_in = 32'h10;
    step();
    chk("t2_in_ready",  64'(in_ready),  64'd0);
    chk("t2_main",      64'(id_instr),  64'(a));
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    got.delete();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t2_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("t2_first",  64'(got[0]), 64'(a));
      chk("t2_second", 64'(got[1]), 64'(b));
      chk("t2_third",  64'(got[2]), 64'(c));
    end

    // Flush while both entries are full.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; instr_in = a; pc_plus4_in = 32'h20;
    step();
    instr_in = b; pc_plus4_in = 32'h24;
    step();
    in_valid = 1'b0;
    chk("t3_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_out_valid", 64'(out_valid), 64'd0);
    chk("t3_in_ready",  64'(in_ready),  64'd1);
    chk("t3_instr",     64'(id_instr),  64'd0);
    chk("t3_cnt",       64'(flush_cnt), 64'd1);

    // Flush coinciding with accept and pop in ONE.
    in_valid = 1'b1; instr_in = a; pc_plus4_in = 32'h30;
    step();
    instr_in = y; pc_plus4_in = 32'h34; out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("t4_ov_during", 64'(out_valid), 64'd0);
    got.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_cnt",       64'(flush_cnt), 64'd2);
    repeat (3) step();
    chk("t4_dropped", 64'(got.size()), 64'd0);

    // Flush on empty does not count; then saturate the narrow counter.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_empty_cnt", 64'(flush_cnt), 64'd2);
    flush = 1'b1; in_valid = 1'b1; instr_in = y;
    repeat (5) step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_cnt16", 64'(flush_cnt),  64'd7);
    chk("t5_cnt2",  64'(flush_cnt2), 64'd3);

    // Async reset with the skid full, between clock edges.
    out_ready = 1'b0; in_valid = 1'b1; instr_in = a; pc_plus4_in = 32'h40;
    step();
    instr_in = b; pc_plus4_in = 32'h44;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid),   64'd0);
    chk("t6_in_ready",  64'(in_ready),    64'd1);
    chk("t6_instr",     64'(id_instr),    64'd0);
    chk("t6_pc",        64'(id_pc_plus4), 64'd0);
    chk("t6_cnt",       64'(flush_cnt),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic checked by the model.
    repeat (3000) begin
      in_valid    = ($urandom % 10) < 7;
      instr_in    = $urandom;
      pc_plus4_in = $urandom;
      out_ready   = ($urandom % 10) < 6;
      flush       = ($urandom % 16) == 0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
